// File: rtl/pb_auto_repeat_if.sv
// Signal bundle between the push-button debouncer side and pb_auto_repeat.
// No backpressure: inputs are sampled every clk edge and outputs are single-cycle strobes/levels.
interface pb_auto_repeat_if #(
  parameter int CNT_W     = 25,
  parameter int RPT_CNT_W = 8
);
  logic                 PB_state;
  logic                 PB_down;
  logic                 PB_up;
  logic                 enable;
  logic [CNT_W-1:0]     hold_delay;
  logic [CNT_W-1:0]     rpt_period;
  logic                 key_pulse;
  logic                 long_press;
  logic                 repeating;
  logic [RPT_CNT_W-1:0] repeat_count;

  modport master (
    output PB_state, PB_down, PB_up, enable, hold_delay, rpt_period,
    input  key_pulse, long_press, repeating, repeat_count
  );

  modport slave (
    input  PB_state, PB_down, PB_up, enable, hold_delay, rpt_period,
    output key_pulse, long_press, repeating, repeat_count
  );
endinterface

// File: rtl/pb_auto_repeat.sv
// Push-button auto-repeat: key event on press, long-press strobe after hold delay, then periodic repeats.
// Optional macro PB_REPEAT_ACCEL_EN halves the repeat period once 8 repeats have been issued.
module pb_auto_repeat #(
  parameter int CNT_W     = 25,
  parameter int RPT_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  pb_auto_repeat_if.slave     bus,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     delay_q;
  logic [CNT_W-1:0]     period_q;
  logic [CNT_W-1:0]     period_eff;
  logic [RPT_CNT_W-1:0] rpt_cnt;
  logic [RPT_CNT_W-1:0] rpt_next;
  logic                 enable_q;
  logic                 key_q;
  logic                 long_q;
  logic                 rep_q;
  logic                 released;
  logic                 hold_term;
  logic                 rpt_term;

`ifdef PB_REPEAT_ACCEL_EN
  localparam logic [RPT_CNT_W-1:0] ACCEL_AT = RPT_CNT_W'(8);
  // Halving is derived from the latched period, so it cannot compound; period 1 stays 1.
  always_comb begin
    period_eff = period_q;
    if ((rpt_cnt >= ACCEL_AT) && (period_q > CNT_W'(1)))
      period_eff = period_q >> 1;
  end
`else
  assign period_eff = period_q;
`endif

  assign released  = !bus.enable || bus.PB_up || !bus.PB_state;
  assign hold_term = (delay_q != '0) && (cnt == delay_q - CNT_W'(1));
  assign rpt_term  = (period_eff != '0) && (cnt == period_eff - CNT_W'(1));
  assign rpt_next  = (rpt_cnt == '1) ? rpt_cnt : rpt_cnt + RPT_CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      delay_q  <= '0;
      period_q <= '0;
      rpt_cnt  <= '0;
      enable_q <= 1'b0;
      key_q    <= 1'b0;
      long_q   <= 1'b0;
      rep_q    <= 1'b0;
    end else begin
      enable_q <= bus.enable;
      key_q    <= 1'b0;
      long_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          // enable_q rejects a press landing on the same cycle enable rises.
          if (bus.PB_down && bus.enable && enable_q) begin
            state    <= S_HOLD;
            key_q    <= 1'b1;
            rpt_cnt  <= '0;
            cnt      <= '0;
            delay_q  <= bus.hold_delay;
            period_q <= bus.rpt_period;
          end
        end
        S_HOLD: begin
          if (released) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (hold_term) begin
            state   <= S_REPEAT;
            key_q   <= 1'b1;
            long_q  <= 1'b1;
            rep_q   <= 1'b1;
            rpt_cnt <= rpt_next;
            cnt     <= '0;
          end else if (delay_q != '0) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (released) begin
            state <= S_IDLE;
            rep_q <= 1'b0;
            cnt   <= '0;
          end else if (rpt_term) begin
            key_q   <= 1'b1;
            rpt_cnt <= rpt_next;
            cnt     <= '0;
          end else if (period_eff != '0) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          rep_q <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.key_pulse    = key_q;
  assign bus.long_press   = long_q;
  assign bus.repeating    = rep_q;
  assign bus.repeat_count = rpt_cnt;
  assign state_dbg        = state;

endmodule
